// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: CPU-side read/status bundle of the UART receive FIFO.
interface uart_rx_fifo_if #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16
);
    logic                          rd_en;
    logic                          err_clr;
    logic                          rd_valid;
    logic [DATA_W-1:0]             rd_data;
    logic                          rd_perr;
    logic                          rd_ferr;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          overrun;
    logic                          break_det;

    modport master (
        output rd_en, err_clr,
        input  rd_valid, rd_data, rd_perr, rd_ferr, fifo_count, overrun, break_det
    );
    modport slave (
        input  rd_en, err_clr,
        output rd_valid, rd_data, rd_perr, rd_ferr, fifo_count, overrun, break_det
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampled UART receiver with majority-voted bits and a
// show-ahead FIFO carrying per-entry parity/framing flags.
module uart_rx_fifo #(
    parameter int DATA_W     = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx,
    input  logic [DIV_W-1:0] baud_div,
    input  logic             parity_en,
    input  logic             odd_n_even,
    uart_rx_fifo_if.slave    bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_W);
    localparam logic [CW-1:0] S_FIRST = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] S_MID   = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] S_LAST  = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0] S_END   = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;

    state_t            state_q, state_d;
    logic              rx1_q, rx2_q, rx3_q;
    logic [DIV_W-1:0]  cnt_q, cnt_d, div_q, div_d;
    logic [CW-1:0]     s_q, s_d;
    logic [BW-1:0]     b_q, b_d;
    logic [1:0]        smp_q, smp_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              perr_q, perr_d, ferr_q, ferr_d, push_q, push_d;
    logic              ovr_q, ovr_d, brk_q, brk_d, brk_set;
    logic [AW:0]       wp_q, wp_d, rp_q, rp_d;
    logic [DATA_W+1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W+1:0] head;
    logic              tick, fall, mid, bend, maj, full, pop, wr, valid;

    assign tick = cnt_q >= div_q;
    assign fall = rx3_q & ~rx2_q;
    assign mid  = tick && s_q == S_LAST;
    assign bend = tick && s_q == S_END;
    // third sample is the live synchronised value; the first two are held
    assign maj  = (smp_q[0] & smp_q[1]) | (rx2_q & (smp_q[0] | smp_q[1]));

    always_comb begin
        state_d = state_q;
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        div_d   = div_q;
        s_d     = tick ? (s_q == S_END ? '0 : s_q + 1'b1) : s_q;
        b_d     = b_q;
        smp_d   = (tick && (s_q == S_FIRST || s_q == S_MID)) ? {smp_q[0], rx2_q} : smp_q;
        data_d  = data_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        push_d  = 1'b0;
        brk_set = 1'b0;
        unique case (state_q)
            IDLE: begin
                div_d = baud_div;
                if (fall) begin
                    state_d = START;
                    cnt_d   = '0;
                    s_d     = '0;
                    b_d     = '0;
                    perr_d  = 1'b0;
                end
            end
            START: state_d = (mid && maj) ? IDLE : bend ? DATA : state_q;
            DATA: begin
                data_d = mid ? {maj, data_q[DATA_W-1:1]} : data_q;
                if (bend) begin
                    if (b_q == BW'(DATA_W - 1)) state_d = parity_en ? PARITY : STOP;
                    else b_d = b_q + 1'b1;
                end
            end
            PARITY: begin
                perr_d  = mid ? ((^data_q ^ maj) != odd_n_even) : perr_q;
                state_d = bend ? STOP : state_q;
            end
            STOP: if (mid) begin
                push_d  = 1'b1;
                ferr_d  = ~maj;
                brk_set = data_q == '0 && !maj;
                state_d = brk_set ? BRK_WAIT : IDLE;
            end
            BRK_WAIT: state_d = rx2_q ? IDLE : state_q;
            default:  state_d = IDLE;
        endcase
    end

    assign valid = wp_q != rp_q;
    assign full  = wp_q[AW] != rp_q[AW] && wp_q[AW-1:0] == rp_q[AW-1:0];
    assign pop   = bus.rd_en && valid;
    // a pop in the same cycle makes room for a push into a full FIFO
    assign wr    = push_q && (!full || pop);
    assign wp_d  = wp_q + {{AW{1'b0}}, wr};
    assign rp_d  = rp_q + {{AW{1'b0}}, pop};
    assign ovr_d = (push_q && full && !pop) || (ovr_q && !bus.err_clr);
    assign brk_d = brk_set || (brk_q && !bus.err_clr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            {rx1_q, rx2_q, rx3_q} <= 3'b111;
            cnt_q   <= '0;
            div_q   <= '0;
            s_q     <= '0;
            b_q     <= '0;
            smp_q   <= '0;
            data_q  <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            push_q  <= 1'b0;
            ovr_q   <= 1'b0;
            brk_q   <= 1'b0;
            wp_q    <= '0;
            rp_q    <= '0;
        end else begin
            state_q <= state_d;
            {rx1_q, rx2_q, rx3_q} <= {rx, rx1_q, rx2_q};
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            s_q     <= s_d;
            b_q     <= b_d;
            smp_q   <= smp_d;
            data_q  <= data_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            push_q  <= push_d;
            ovr_q   <= ovr_d;
            brk_q   <= brk_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem_q[wp_q[AW-1:0]] <= {ferr_q, perr_q, data_q};
    end

    assign head           = valid ? mem_q[rp_q[AW-1:0]] : '0;
    assign bus.rd_valid   = valid;
    assign bus.rd_data    = head[DATA_W-1:0];
    assign bus.rd_perr    = head[DATA_W];
    assign bus.rd_ferr    = head[DATA_W+1];
    assign bus.fifo_count = wp_q - rp_q;
    assign bus.overrun    = ovr_q;
    assign bus.break_det  = brk_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed and randomized frames against a frame-level model;
// a monitor pops the DUT FIFO and compares each entry against the expected queue.
module tb_uart_rx_fifo;
    localparam int OS = 16, DEPTH = 16;

    logic        clk = 0, reset = 1, rx = 1, parity_en = 0, odd_n_even = 0;
    logic [15:0] baud_div = 16'd3;

    uart_rx_fifo_if #(.DATA_W(8), .FIFO_DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(.DATA_W(8), .OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH), .DIV_W(16)) dut (
        .clk(clk), .reset(reset), .rx(rx), .baud_div(baud_div),
        .parity_en(parity_en), .odd_n_even(odd_n_even), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {logic [7:0] d; logic pe; logic fe;} ent_t;
    ent_t exp_q[$];
    int   checks = 0, errors = 0;
    bit   auto_rd = 0, ovr_m = 0, brk_m = 0;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, got, want);
        end
    endtask

    function automatic void model_push(input ent_t e);
        if (exp_q.size() < DEPTH) exp_q.push_back(e);
        else ovr_m = 1;
    endfunction

    // One frame: start, 8 data bits LSB first, optional parity, one stop bit.
    task automatic send(input logic [7:0] d, input logic pb, input logic st, input int spike, input int idle);
        int   p;
        logic bits[$];
        ent_t e;
        p    = OS * (int'(baud_div) + 1);
        e.d  = d;
        e.fe = ~st;
        e.pe = parity_en && (((($countones(d) + int'(pb)) % 2) != 0) != odd_n_even);
        model_push(e);
        if (d == 8'h00 && !st) brk_m = 1;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (parity_en) bits.push_back(pb);
        bits.push_back(st);
        @(negedge clk);
        for (int i = 0; i < bits.size(); i++)
            for (int j = 0; j < p; j++) begin
                rx = (i == spike && j == p / 2) ? 1'b1 : bits[i];
                @(negedge clk);
            end
        rx = 1'b1;
        repeat (idle) @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        bus.err_clr = 1;
        @(negedge clk);
        bus.err_clr = 0;
        @(negedge clk);
    endtask

    initial begin
        ent_t e;
        bus.rd_en = 0;
        forever begin
            @(negedge clk);
            if (auto_rd && !reset && bus.rd_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected entry: got data %0h, expected none", bus.rd_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("entry data", bus.rd_data, e.d);
                    chk("entry perr", bus.rd_perr, e.pe);
                    chk("entry ferr", bus.rd_ferr, e.fe);
                end
                bus.rd_en = 1;
                @(negedge clk);
                bus.rd_en = 0;
            end
        end
    end

    initial begin
        logic [7:0] d;
        bus.err_clr = 0;
        repeat (3) @(negedge clk);
        chk("reset rd_valid", bus.rd_valid, 0);
        chk("reset fifo_count", bus.fifo_count, 0);
        chk("reset overrun", bus.overrun, 0);
        chk("reset break_det", bus.break_det, 0);
        chk("reset rd_data", {bus.rd_ferr, bus.rd_perr, bus.rd_data}, 0);
        reset = 0;
        repeat (5) @(negedge clk);

        // 8N1 with exact rd_valid latency
        fork
            send(8'h41, 1'b0, 1'b1, -1, 32);
            begin
                @(negedge clk);
                repeat (619) @(negedge clk);
                chk("latency before", bus.rd_valid, 0);
                @(negedge clk);
                chk("latency rise", bus.rd_valid, 1);
            end
        join
        chk("8N1 fifo_count", bus.fifo_count, 1);
        chk("8N1 rd_data", bus.rd_data, 8'h41);
        chk("8N1 flags", {bus.rd_perr, bus.rd_ferr}, 0);
        auto_rd = 1;
        drain();
        chk("8N1 popped valid", bus.rd_valid, 0);
        chk("8N1 popped count", bus.fifo_count, 0);

        // parity and parity-correct break
        parity_en  = 1;
        odd_n_even = 0;
        send(8'h55, 1'b1, 1'b1, -1, 32);
        send(8'h55, 1'b0, 1'b1, -1, 32);
        send(8'h00, 1'b0, 1'b0, -1, 32);
        drain();
        chk("parity break_det", bus.break_det, 1);
        pulse_clr();
        brk_m = 0;
        chk("break_det cleared", bus.break_det, 0);

        // glitch start, then spike inside a data bit
        parity_en = 0;
        @(negedge clk);
        rx = 0;
        repeat (16) @(negedge clk);
        rx = 1;
        repeat (3 * 64) @(negedge clk);
        chk("glitch no push", bus.fifo_count, 0);
        send(8'hA5, 1'b0, 1'b1, 2, 32);
        drain();

        // overrun
        auto_rd = 0;
        for (int i = 0; i < 17; i++) send(8'h41 + 8'(i), 1'b0, 1'b1, -1, 8);
        repeat (10) @(negedge clk);
        chk("overrun fifo_count", bus.fifo_count, 16);
        chk("overrun flag", bus.overrun, ovr_m);
        chk("overrun model", ovr_m, 1);
        auto_rd = 1;
        drain();
        pulse_clr();
        ovr_m = 0;
        chk("overrun cleared", bus.overrun, 0);

        // long break: one entry only
        @(negedge clk);
        e_push_break();
        rx = 0;
        repeat (12 * 64) @(negedge clk);
        rx = 1;
        repeat (3 * 64) @(negedge clk);
        drain();
        chk("long break det", bus.break_det, 1);
        chk("long break count", bus.fifo_count, 0);
        send(8'h5A, 1'b0, 1'b1, -1, 32);
        drain();

        // reset in data bit 4 with an entry held and break_det still set
        auto_rd = 0;
        send(8'h33, 1'b0, 1'b1, -1, 8);
        d = 8'h7E;
        rx = 0;
        repeat (64) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            repeat (64) @(negedge clk);
        end
        rx = d[4];
        repeat (32) @(negedge clk);
        chk("pre-reset count", bus.fifo_count, 1);
        reset = 1;
        #1;
        chk("mid reset valid", bus.rd_valid, 0);
        chk("mid reset count", bus.fifo_count, 0);
        chk("mid reset data", {bus.rd_ferr, bus.rd_perr, bus.rd_data}, 0);
        chk("mid reset break", bus.break_det, 0);
        chk("mid reset overrun", bus.overrun, 0);
        exp_q.delete();
        brk_m = 0;
        rx = 1;
        repeat (5) @(negedge clk);
        reset = 0;
        auto_rd = 1;
        repeat (5) @(negedge clk);
        send(8'h7E, 1'b0, 1'b1, -1, 32);
        drain();

        // randomized frames
        for (int n = 0; n < 40; n++) begin
            baud_div   = 16'($urandom_range(0, 3));
            parity_en  = 1'($urandom);
            odd_n_even = 1'($urandom);
            d = ($urandom % 8 == 0) ? 8'h00 : 8'($urandom);
            send(d, 1'($urandom), ($urandom % 6) != 0,
                 ($urandom % 2) ? int'($urandom_range(1, 8)) : -1, int'($urandom_range(4, 40)));
        end
        drain();
        chk("random break_det", bus.break_det, brk_m);
        chk("random overrun", bus.overrun, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    task automatic e_push_break();
        ent_t e;
        e.d  = 8'h00;
        e.pe = 1'b0;
        e.fe = 1'b1;
        model_push(e);
        brk_m = 1;
    endtask
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver with oversampled, majority-voted bit recovery, configurable frame format and a show-ahead receive FIFO. It carries per-entry parity/framing error flags and sticky overrun/break status. It is the next-generation receive path of the local-bus UART and replaces the fixed 8-bit single-register receiver. A CPU-side wrapper pops entries with rd_en.

Parameters:
DATA_W, 8, data bits per frame; legal range 5..9.
OVERSAMPLE, 16, sample ticks per bit; even, >= 8.
FIFO_DEPTH, 16, receive FIFO entries; power of 2, >= 2.
DIV_W, 16, width of the baud divisor.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
rx  input  1  serial line, idle high; asynchronous to clk
baud_div  input  DIV_W  sample tick every baud_div+1 clocks
parity_en  input  1  1 = parity bit follows the data bits
odd_n_even  input  1  1 = odd parity, 0 = even parity
rd_en  input  1  pop the head entry; ignored when empty
err_clr  input  1  one-cycle pulse that clears the sticky flags
rd_valid  output  1  FIFO not empty
rd_data  output  DATA_W  head entry data (show-ahead)
rd_perr  output  1  head entry parity error
rd_ferr  output  1  head entry framing error (stop bit sampled 0)
fifo_count  output  $clog2(FIFO_DEPTH)+1  number of entries
overrun  output  1  sticky: a frame was dropped because the FIFO was full
break_det  output  1  sticky: a break condition was received

Behaviour:
- Reset (async, active-high) values: rd_valid=0, fifo_count=0, overrun=0, break_det=0, rd_data/rd_perr/rd_ferr=0. The FSM goes to IDLE, the rx synchroniser is preset to 1, and the tick counter is 0. Reset mid-frame discards the partial frame.
- rx passes through a 2-flop synchroniser (preset 1). All FSM decisions use the synchronised value.
- Tick generator: a free-running counter reloads on reaching baud_div and pulses tick for one clock. baud_div is latched at start detection and held for the whole frame. baud_div=0 gives a tick every clock.
- Bit value = majority of three samples taken at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 within the bit. The bit period is OVERSAMPLE ticks.
- FSM states:
  - IDLE: a 1->0 edge on the synchronised rx goes to START and resets the tick phase.
  - START: if the majority sample is 1 (glitch), go back to IDLE with nothing pushed. Otherwise go to DATA.
  - DATA: receive DATA_W bits, LSB first. Then go to PARITY if parity_en, else go to STOP.
  - PARITY: perr = (XOR of the data bits, XOR'd with the parity bit) != odd_n_even.
  - STOP: after the majority sample, push {ferr = ~stop, perr, data} one clock later, then go to IDLE. If data==0 and stop==0, set break_det and go to BRK_WAIT instead.
  - BRK_WAIT: stay until synchronised rx==1, then go to IDLE. No further entries are pushed during a break.
- Latency: rd_valid rises 2 clocks after the last stop-bit sample tick (1 clock to push, 1 clock for the flag) when the FIFO was empty.
- With parity_en=0, perr is 0.
- Only one stop bit is checked; any extra idle time is accepted.
- FIFO:
  - Circular buffer with read/write pointers one bit wider than the address.
  - Full when the pointer MSBs differ and the addresses are equal.
  - rd_data/rd_perr/rd_ferr show the head entry combinationally from registered storage.
  - Pop when rd_en && rd_valid; rd_en on an empty FIFO has no effect.
- Push when full: if a pop happens in the same cycle, the push is accepted and fifo_count is unchanged. Otherwise the frame is dropped, overrun is set, and the FIFO contents are untouched.
- Simultaneous push and pop when not full: fifo_count is unchanged and both pointers advance.
- err_clr clears overrun and break_det. If a set and a clear occur in the same cycle, the set wins.
- Changing parity_en/odd_n_even mid-frame gives an undefined result for that frame only; the following frames are correct.

Test Plan:
- 8N1 receive: baud_div=3 (64 clocks per bit), parity_en=0; send 0x41 -> rd_valid=1 2 clocks after the stop sample, rd_data=0x41, rd_perr=0, rd_ferr=0, fifo_count=1. Pulse rd_en -> rd_valid=0, fifo_count=0.
- Parity: parity_en=1, odd_n_even=0; send 0x55 with parity bit 1 -> rd_data=0x55, rd_perr=1. Send 0x55 with parity bit 0 -> rd_perr=0. Send 0x00 with stop=0 and parity correct -> rd_ferr=1, break_det=1.
- Glitch and noise: rx low for 16 clocks only -> no push, FSM back in IDLE. A single-clock high spike at the centre of a data bit of 0xA5 -> 0xA5 received (majority vote).
- Overrun: send 0x41..0x51 (17 frames) without reading, FIFO_DEPTH=16 -> fifo_count=16, overrun=1. Popping returns 0x41..0x50 in order. err_clr -> overrun=0.
- Break: hold rx low for 12 bit times -> exactly one entry (data 0x00, ferr=1), break_det=1, no further entries. Release rx and send 0x5A -> 0x5A received cleanly.
- Reset mid-frame: assert reset during data bit 4 -> all outputs return to reset values immediately. After release, send 0x7E -> 0x7E received with no errors.
